// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

   localparam int unsigned STALL_CNT_W = 16;

   // Index + 1, wrapping to 0 after n-1.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotating priority encoder: first set bit of vec scanning from ptr upward with wrap.
module rr_pick
   import fifo_pkg::*;
#(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] vec,
   input  logic [IDW-1:0]   ptr,
   output logic             found,
   output logic [IDW-1:0]   idx
);

   // Scan from farthest to nearest so the closest candidate to ptr wins.
   always_comb begin
      int unsigned cand;
      found = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
         cand = 32'(ptr) + 32'(k);
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (vec[IDW'(cand)]) begin
            found = 1'b1;
            idx   = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the FIFO write port between N_REQ requesters.
// Packet locking is compiled in with FIFO_WR_ARB_PKT_LOCK_EN.
module fifo_wr_arb
   import fifo_pkg::*;
#(
   parameter  int unsigned N_REQ     = 4,
   parameter  int unsigned FIFO_DWTH = 8,
   localparam int unsigned IDW       = $clog2(N_REQ)
) (
   input  logic                       clk_w,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ*FIFO_DWTH-1:0] req_data,
   input  logic [N_REQ-1:0]           req_last,
   output logic [N_REQ-1:0]           req_ready,
   input  logic                       fifo_full,
   output logic                       fifo_wren,
   output logic [FIFO_DWTH-1:0]       fifo_din,
   output logic                       grant_valid,
   output logic [IDW-1:0]             grant_id,
   output logic [STALL_CNT_W-1:0]     stall_cnt
);

   arb_state_e             state_q, state_d;
   logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]         lock_id_q, lock_id_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic           pick_found;
   logic [IDW-1:0] pick_idx;
   logic [IDW-1:0] sel_id;
   logic [IDW-1:0] ptr_nxt;
   logic           sel_valid;
   logic           accept;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .vec   (req_valid),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // A locked packet owns the port even while its requester is idle.
   assign sel_id    = (state_q == ARB_LOCK) ? lock_id_q : pick_idx;
   assign sel_valid = (state_q == ARB_LOCK) ? req_valid[sel_id] : pick_found;
   assign accept    = sel_valid && !fifo_full && !rst;
   assign ptr_nxt   = IDW'(rr_next(32'(sel_id), N_REQ));

   assign grant_valid = sel_valid && !rst;
   assign grant_id    = grant_valid ? sel_id : '0;
   assign fifo_wren   = accept;
   assign req_ready   = accept ? (N_REQ'(1) << sel_id) : '0;
   assign fifo_din    = accept ? req_data[sel_id*FIFO_DWTH +: FIFO_DWTH] : '0;
   assign stall_cnt   = rst ? '0 : stall_cnt_q;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      lock_id_d   = lock_id_q;
      stall_cnt_d = stall_cnt_q;

      if ((|req_valid) && fifo_full && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);

      if (accept) begin
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
         if (state_q == ARB_IDLE) begin
            if (req_last[sel_id]) begin
               rr_ptr_d = ptr_nxt;
            end else begin
               state_d   = ARB_LOCK;
               lock_id_d = sel_id;
            end
         end else if (req_last[sel_id]) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = ptr_nxt;
         end
`else
         rr_ptr_d = ptr_nxt;
`endif
      end
   end

`ifndef FIFO_WR_ARB_PKT_LOCK_EN
   logic unused_last;
   assign unused_last = ^req_last;
`endif

   always_ff @(posedge clk_w) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         lock_id_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_id_q   <= lock_id_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb; works with or without FIFO_WR_ARB_PKT_LOCK_EN.
module tb_fifo_wr_arb;

   localparam int N = 4;
   localparam int W = 8;
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic         clk_w = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req_valid = '0;
   logic [N-1:0] req_last = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0] req_ready;
   logic         fifo_full = 1'b0;
   logic         fifo_wren;
   logic [W-1:0] fifo_din;
   logic         grant_valid;
   logic [1:0]   grant_id;
   logic [15:0]  stall_cnt;

   fifo_wr_arb #(.N_REQ(N), .FIFO_DWTH(W)) dut (
      .clk_w(clk_w), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
      .fifo_wren(fifo_wren), .fifo_din(fifo_din), .grant_valid(grant_valid),
      .grant_id(grant_id), .stall_cnt(stall_cnt)
   );

   always #5 clk_w = ~clk_w;

   int n_pass = 0;
   int n_chk  = 0;

   // Reference model state
   int m_ptr, m_lock, m_lid, m_stall;
   bit acc;
   int acc_id;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_ptr = 0; m_lock = 0; m_lid = 0; m_stall = 0;
   endtask

   task automatic do_reset(input int n, input logic [N-1:0] v);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_w);
         rst = 1'b1; req_valid = v; req_last = '0; fifo_full = 1'b0;
         #1;
         chk("rst_wren", fifo_wren, 0);
         chk("rst_ready", req_ready, 0);
         chk("rst_stall", stall_cnt, 0);
         chk("rst_gv", grant_valid, 0);
      end
      model_reset();
   endtask

   // Drive one cycle, compare every output with the model, then advance the model.
   task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic [N-1:0] l, input logic f);
      bit egv, eacc;
      int eid;
      logic [W-1:0] edin;
      logic [N-1:0] erdy;
      @(negedge clk_w);
      rst = 1'b0; req_valid = v; req_data = d; req_last = l; fifo_full = f;
      #1;
      egv = 1'b0; eid = 0;
      if (m_lock != 0) begin
         egv = v[m_lid]; eid = m_lid;
      end else begin
         for (int k = 0; k < N; k++)
            if (!egv && v[(m_ptr + k) % N]) begin egv = 1'b1; eid = (m_ptr + k) % N; end
      end
      eacc = egv && !f;
      edin = eacc ? d[eid*W +: W] : '0;
      erdy = '0;
      if (eacc) erdy[eid] = 1'b1;
      chk("grant_valid", grant_valid, egv);
      chk("grant_id", grant_id, egv ? eid : 0);
      chk("fifo_wren", fifo_wren, eacc);
      chk("req_ready", req_ready, erdy);
      chk("fifo_din", fifo_din, edin);
      chk("stall_cnt", stall_cnt, m_stall);
      if ((|v) && f && m_stall < 65535) m_stall++;
      acc = eacc; acc_id = eid;
      if (eacc) begin
         if (LOCK_EN) begin
            if (m_lock == 0) begin
               if (l[eid]) m_ptr = (eid + 1) % N;
               else begin m_lock = 1; m_lid = eid; end
            end else if (l[eid]) begin
               m_lock = 0; m_ptr = (eid + 1) % N;
            end
         end else begin
            m_ptr = (eid + 1) % N;
         end
      end
   endtask

   typedef struct {
      logic [N-1:0] v;
      logic         f;
      bit           egv;
      int           eid;
      bit           ewr;
      logic [W-1:0] edin;
   } vec_t;

   vec_t tbl[9];
   int cnt[N];
   int exp_pkt[8];
   logic [N-1:0] pv, pl;
   logic [N*W-1:0] pd;

   initial begin
      tbl[0] = '{4'hF, 1'b0, 1'b1, 0, 1'b1, 8'h11};
      tbl[1] = '{4'hF, 1'b0, 1'b1, 1, 1'b1, 8'h22};
      tbl[2] = '{4'h1, 1'b0, 1'b1, 0, 1'b1, 8'h11};
      tbl[3] = '{4'hC, 1'b1, 1'b1, 2, 1'b0, 8'h00};
      tbl[4] = '{4'hC, 1'b0, 1'b1, 2, 1'b1, 8'h33};
      tbl[5] = '{4'h9, 1'b0, 1'b1, 3, 1'b1, 8'h44};
      tbl[6] = '{4'h0, 1'b0, 1'b0, 0, 1'b0, 8'h00};
      tbl[7] = '{4'h6, 1'b0, 1'b1, 1, 1'b1, 8'h22};
      tbl[8] = '{4'h2, 1'b0, 1'b1, 1, 1'b1, 8'h22};

      // Reset with everyone requesting, then the directed table
      do_reset(3, 4'hF);
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].v, 32'h44332211, 4'hF, tbl[i].f);
         chk("tbl_gv", grant_valid, tbl[i].egv);
         chk("tbl_id", grant_id, tbl[i].eid);
         chk("tbl_wren", fifo_wren, tbl[i].ewr);
         chk("tbl_din", fifo_din, tbl[i].edin);
      end

      // Fairness: 100 beats, all valid
      do_reset(1, 4'h0);
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int i = 0; i < 100; i++) begin
         step(4'hF, 32'h44332211, 4'hF, 1'b0);
         chk("fair_seq", grant_id, i % N);
         if (fifo_wren) cnt[grant_id]++;
      end
      for (int i = 0; i < N; i++) chk("fair_cnt", cnt[i], 25);

      // Back-pressure on requester 2
      do_reset(1, 4'h0);
      for (int i = 0; i < 5; i++) begin
         step(4'b0100, 32'h44A52211, 4'hF, 1'b1);
         chk("bp_nowrite", fifo_wren, 0);
      end
      step(4'b0100, 32'h44A52211, 4'hF, 1'b0);
      chk("bp_stall", stall_cnt, 5);
      chk("bp_wren", fifo_wren, 1);
      chk("bp_din", fifo_din, 8'hA5);

      // Packet from requester 1 competing with requester 0
      do_reset(1, 4'h0);
      step(4'b0001, 32'h44332211, 4'hF, 1'b0);
      for (int c = 0; c < 8; c++)
         exp_pkt[c] = LOCK_EN ? ((c < 4) ? 1 : 0) : ((c % 2 == 0) ? 1 : 0);
      begin
         int b;
         b = 0;
         for (int c = 0; c < 8; c++) begin
            logic [N-1:0] v, l;
            logic [N*W-1:0] d;
            v = {2'b00, (b < 4), 1'b1};
            l = {2'b00, (b == 3), 1'b1};
            d = {16'h0, 8'(8'hB0 + b), 8'h11};
            step(v, d, l, 1'b0);
            chk("pkt_id", grant_id, exp_pkt[c]);
            if (req_ready[1]) b++;
         end
      end

      // Lock bubble, then reset mid-packet
      do_reset(1, 4'h0);
      step(4'b1000, 32'h44332211, 4'h0, 1'b0);
      chk("bub_first", grant_id, 3);
      for (int i = 0; i < 2; i++) begin
         step(4'b0011, 32'h44332211, 4'h0, 1'b0);
         chk("bub_wren", fifo_wren, LOCK_EN ? 0 : 1);
         chk("bub_gv", grant_valid, LOCK_EN ? 0 : 1);
      end
      do_reset(1, 4'b1001);
      step(4'b1001, 32'h44332211, 4'hF, 1'b0);
      chk("post_rst_id", grant_id, 0);

      // Randomized traffic against the model; requesters hold until accepted
      do_reset(1, 4'h0);
      pv = '0; pl = '0; pd = '0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pv[i]) begin
               pv[i] = ($urandom % 3) != 0;
               pd[i*W +: W] = W'($urandom);
               pl[i] = ($urandom % 2) != 0;
            end
         end
         step(pv, pd, pl, ($urandom % 4) == 0);
         if (acc) pv[acc_id] = 1'b0;
      end

      // Stall counter saturation
      do_reset(1, 4'h0);
      for (int i = 0; i < 70000; i++) begin
         @(negedge clk_w);
         rst = 1'b0; req_valid = 4'hF; fifo_full = 1'b1;
         #1;
         if (i == 65534) chk("sat_pre", stall_cnt, 65534);
         if (i == 65535) chk("sat_hit", stall_cnt, 65535);
      end
      @(negedge clk_w);
      #1;
      chk("sat_hold", stall_cnt, 65535);
      chk("sat_nowrite", fifo_wren, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write-side arbiter that shares the single write port of the asynchronous FIFO (`wren`/`din`/`full`) between N requesters in the write clock domain. It selects one requester per accepted beat, or holds the selection for a whole packet when packet locking is compiled in. It drives the FIFO write port directly and counts cycles lost to FIFO back-pressure. The block sits between the producer channels and the FIFO write port.

## Interface
- `N_REQ`, 4, number of requesters (2..16)
- `FIFO_DWTH`, 8, data width; must match the FIFO `FIFO_DWTH`
- `IDW`, $clog2(N_REQ), width of the grant id (localparam)
- `clk_w`  in  1  write clock, shared with FIFO `clk_w`
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  N_REQ  per-requester beat valid
- `req_data`  in  N_REQ*FIFO_DWTH  packed beats; requester i occupies [i*FIFO_DWTH +: FIFO_DWTH]
- `req_last`  in  N_REQ  final beat of the packet; used only with packet lock
- `req_ready`  out  N_REQ  beat accepted this cycle (one-hot or zero)
- `fifo_full`  in  1  FIFO `full`
- `fifo_wren`  out  1  to FIFO `wren`
- `fifo_din`  out  FIFO_DWTH  to FIFO `din`
- `grant_valid`  out  1  a requester is selected this cycle
- `grant_id`  out  IDW  selected requester index (0 when none)
- `stall_cnt`  out  16  saturating count of back-pressure cycles

## Operation
- Registered state: `rr_ptr` (IDW, highest priority index), `state` {IDLE, LOCK}, `lock_id` (IDW), `stall_cnt`.
- Selection in IDLE: the first i with `req_valid[i]` set, scanning `rr_ptr`, `rr_ptr+1`, … with wrap modulo N_REQ. Selection in LOCK: `lock_id` only, whether or not its valid is set.
- `grant_valid` = a selection exists and, in LOCK, `req_valid[lock_id]` is set.
- A beat is accepted when `grant_valid && !fifo_full`. On accept: `req_ready[grant_id]`=1, `fifo_wren`=1, `fifo_din`=selected data.
- When no beat is accepted: `req_ready`=0, `fifo_wren`=0, `fifo_din`=0.
- Pointer update on accept: `rr_ptr` <= `grant_id`+1, wrapping to 0 after N_REQ-1. In LOCK, the pointer updates only on the last beat of the packet.
- `stall_cnt` increments when any `req_valid` is set and `fifo_full`=1. It saturates at 0xFFFF.
- A requester must hold `req_valid` and `req_data` stable until it sees `req_ready`.
- The FIFO's internal `wren & !full` gating is never relied upon: `fifo_wren` is never asserted while `fifo_full`=1.

## Timing
- Outputs `req_ready`, `fifo_wren`, `fifo_din`, `grant_*` are combinational from current state and inputs. There are zero cycles from `req_valid` to the FIFO write.
- The FIFO write occurs on the same `clk_w` edge that completes the handshake.
- While `rst`=1, all outputs are forced to 0. Registered values reset to `rr_ptr`=0, `state`=IDLE, `lock_id`=0, `stall_cnt`=0.
- Reset asserted mid-packet abandons the lock. The first cycle after reset arbitrates from requester 0.
- `fifo_full` asserting with a beat pending: no accept and no pointer move. The same requester wins when full clears, unless in IDLE a higher-priority requester appears first.
- Single active requester: one beat per cycle while not full; `rr_ptr` stays at id+1.

## Configuration
- `FIFO_WR_ARB_PKT_LOCK_EN` defined:
  - An accepted beat with `req_last`=0 in IDLE moves to LOCK and sets `lock_id`.
  - An accepted beat with `req_last`=1 in LOCK returns to IDLE and advances `rr_ptr`.
  - A single-beat packet (`last`=1 from IDLE) stays in IDLE.
  - In LOCK, a deasserted `req_valid[lock_id]` produces bubbles; other requesters are not served.
- Not defined: `state` is permanently IDLE and `req_last` is ignored. Arbitration is per beat.

## Structure
- Shared package `fifo_pkg`:
  - arbiter state enum (`ARB_IDLE`, `ARB_LOCK`)
  - `STALL_CNT_W` = 16
  - `rr_next` function (index+1 modulo N)
- One sub-module: `rr_pick`, a rotating priority encoder. Inputs: `vec[N_REQ]`, `ptr`. Outputs: `found`, `idx`. Purely combinational; all state remains in `fifo_wr_arb`.

## Test plan
- Reset: hold `rst` 3 cycles with all `req_valid`=1. Required: `fifo_wren`=0, `req_ready`=0, `stall_cnt`=0. The first post-reset grant goes to id 0.
- Fairness: N_REQ=4, all valid continuously, FIFO never full. Required grants: 0,1,2,3,0,1… and each requester gets exactly 25 of 100 beats.
- Back-pressure: requester 2 valid with data 0xA5, `fifo_full`=1 for 5 cycles. Required: no write, `stall_cnt`=5. When full drops, a single write of 0xA5 occurs in that cycle.
- Packet lock (macro on): requester 1 sends 4 beats with `last` on beat 4, requester 0 valid throughout. Required: four consecutive writes from id 1, then id 0. With the macro off, required grants alternate 1,0,1,0.
- Lock bubble and reset (macro on): requester 3 drops valid mid-packet for 2 cycles. Required: 2 idle cycles with no grant to others. Asserting `rst` in the next cycle returns the arbiter to IDLE with `rr_ptr`=0.
- Saturation: force 70000 stall cycles. Required: `stall_cnt` holds at 0xFFFF.
